// File: rtl/ship_pkg.sv
// Shared types and constants for the ship heading controller: rotation FSM
// states and the 16-step sine table behind the optional SHIP_HEADING_VEC_EN vector.
package ship_pkg;

    localparam int ANGLE_W    = 4;
    localparam int NUM_ANGLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } heading_state_e;

    // 127 * sin(idx * 22.5 deg), rounded
    function automatic logic signed [7:0] heading_sin(input logic [ANGLE_W-1:0] idx);
        logic signed [7:0] val;
        case (idx)
            4'd0:    val = 8'sd0;
            4'd1:    val = 8'sd49;
            4'd2:    val = 8'sd90;
            4'd3:    val = 8'sd117;
            4'd4:    val = 8'sd127;
            4'd5:    val = 8'sd117;
            4'd6:    val = 8'sd90;
            4'd7:    val = 8'sd49;
            4'd8:    val = 8'sd0;
            4'd9:    val = -8'sd49;
            4'd10:   val = -8'sd90;
            4'd11:   val = -8'sd117;
            4'd12:   val = -8'sd127;
            4'd13:   val = -8'sd117;
            4'd14:   val = -8'sd90;
            4'd15:   val = -8'sd49;
            default: val = 8'sd0;
        endcase
        return val;
    endfunction

    function automatic logic signed [7:0] heading_cos(input logic [ANGLE_W-1:0] idx);
        logic [ANGLE_W-1:0] shifted;
        shifted = idx + 4'd4;
        return heading_sin(shifted);
    endfunction

endpackage

// File: rtl/heading_vec_lut.sv
// Combinational angle -> (dx, dy) heading lookup, used when SHIP_HEADING_VEC_EN is defined.
// Angle 4 points up the screen (dy negative), angles advance clockwise.
module heading_vec_lut
    import ship_pkg::*;
(
    input  logic [ANGLE_W-1:0] angle_i,
    output logic signed [7:0]  dx_o,
    output logic signed [7:0]  dy_o
);

    // Heading is the negated (cos, sin) pair so angle 0 faces left and angle 4 faces up
    always_comb begin
        dx_o = -heading_cos(angle_i);
        dy_o = -heading_sin(angle_i);
    end

endmodule

// File: rtl/ship_heading_ctrl.sv
// Ship sprite angle controller: frame-tick sampled rotate buttons with hold auto-repeat.
// Define SHIP_HEADING_VEC_EN to also register a signed (dx, dy) heading vector.
module ship_heading_ctrl
    import ship_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 12,
    parameter int unsigned REPEAT_RATE  = 4,
    parameter int unsigned INIT_ANGLE   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               lock,
    output logic [ANGLE_W-1:0] angle,
    output logic               angle_upd,
    output logic signed [7:0]  dx,
    output logic signed [7:0]  dy
);

    localparam logic [7:0]         DELAY_LOAD = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0]         RATE_LOAD  = 8'(REPEAT_RATE - 1);
    localparam logic [ANGLE_W-1:0] INIT_ANG   = 4'(INIT_ANGLE);

    heading_state_e     state_q, state_d;
    logic               held_right_q, held_right_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic               upd_q, upd_d;

    logic dir_right_s, dir_left_s, dir_any_s, step_s, step_right_s;

    assign dir_right_s = btn_right & ~btn_left;
    assign dir_left_s  = btn_left & ~btn_right;
    assign dir_any_s   = dir_right_s | dir_left_s;

    // Rotation FSM: decides at each frame tick whether a step happens and in which direction
    always_comb begin
        state_d      = state_q;
        held_right_d = held_right_q;
        cnt_d        = cnt_q;
        step_s       = 1'b0;
        step_right_s = 1'b0;
        if (frame_tick) begin
            if (lock || !dir_any_s) begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        step_s       = 1'b1;
                        step_right_s = dir_right_s;
                        held_right_d = dir_right_s;
                        cnt_d        = DELAY_LOAD;
                        state_d      = ST_DELAY;
                    end
                    ST_DELAY, ST_REPEAT: begin
                        // A direction reversal counts as a fresh press
                        if (dir_right_s != held_right_q) begin
                            step_s       = 1'b1;
                            step_right_s = dir_right_s;
                            held_right_d = dir_right_s;
                            cnt_d        = DELAY_LOAD;
                            state_d      = ST_DELAY;
                        end else if (cnt_q == 8'd0) begin
                            step_s       = 1'b1;
                            step_right_s = held_right_q;
                            cnt_d        = RATE_LOAD;
                            state_d      = ST_REPEAT;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Next angle and the one-cycle change pulse
    always_comb begin
        angle_d = angle_q;
        upd_d   = step_s;
        if (step_s) begin
            if (step_right_s) begin
                angle_d = angle_q + 4'd1;
            end else begin
                angle_d = angle_q - 4'd1;
            end
        end else begin
            angle_d = angle_q;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            held_right_q <= 1'b0;
            cnt_q        <= 8'd0;
            angle_q      <= INIT_ANG;
            upd_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_right_q <= held_right_d;
            cnt_q        <= cnt_d;
            angle_q      <= angle_d;
            upd_q        <= upd_d;
        end
    end

    assign angle     = angle_q;
    assign angle_upd = upd_q;

`ifdef SHIP_HEADING_VEC_EN
    logic signed [7:0] dx_q, dx_d, dy_q, dy_d, lut_dx_s, lut_dy_s;

    heading_vec_lut u_vec_lut (
        .angle_i (angle_d),
        .dx_o    (lut_dx_s),
        .dy_o    (lut_dy_s)
    );

    // Vector reloads on every tick so it becomes valid after the first tick out of reset
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (frame_tick) begin
            dx_d = lut_dx_s;
            dy_d = lut_dy_s;
        end else begin
            dx_d = dx_q;
            dy_d = dy_q;
        end
    end

    // Heading vector registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dx_q <= 8'sd0;
            dy_q <= 8'sd0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx = dx_q;
    assign dy = dy_q;
`else
    assign dx = 8'sd0;
    assign dy = 8'sd0;
`endif

endmodule

// File: tb/tb_ship_heading_ctrl.sv
// Self-checking bench for ship_heading_ctrl: vector table, hand sequences and a
// randomized run against a hold-duration reference model (honours SHIP_HEADING_VEC_EN).
module tb_ship_heading_ctrl;

    localparam int D    = 12;
    localparam int R    = 4;
    localparam int INIT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_tick = 1'b0;
    logic              btn_left = 1'b0;
    logic              btn_right = 1'b0;
    logic              lock = 1'b0;
    logic [3:0]        angle;
    logic              angle_upd;
    logic signed [7:0] dx, dy;

    int n_checks = 0;
    int n_err    = 0;

    ship_heading_ctrl #(.REPEAT_DELAY(D), .REPEAT_RATE(R), .INIT_ANGLE(INIT)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_left(btn_left),
        .btn_right(btn_right), .lock(lock), .angle(angle), .angle_upd(angle_upd),
        .dx(dx), .dy(dy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ft, l, r, lk;
        logic [3:0] ang;
        logic       upd;
    } vec_t;
    vec_t tbl[21];

    // reference model state
    int         m_run;
    int         m_prev;
    int         m_angle;
    int         m_upd;
    int         m_dx, m_dy;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // heading for an angle: 22.5 deg steps clockwise from "up" at angle 4, magnitude 127
    task automatic exp_vec(input int a, output int ex, output int ey);
`ifdef SHIP_HEADING_VEC_EN
        real th;
        th = (a - 4) * 22.5 * 3.14159265358979 / 180.0;
        ex = rnd(127.0 * $sin(th));
        ey = rnd(-127.0 * $cos(th));
`else
        ex = a - a;
        ey = 0;
`endif
    endtask

    task automatic model_reset();
        m_run = -1; m_prev = 0; m_angle = INIT; m_upd = 0; m_dx = 0; m_dy = 0;
    endtask

    task automatic model_cycle(input logic ft, input logic l, input logic r, input logic lk);
        int d;
        int step;
        if (!ft) begin
            m_upd = 0;
            return;
        end
        d = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        step = 0;
        if (lk || d == 0) begin
            m_run = -1;
        end else if (m_run < 0 || d != m_prev) begin
            m_run = 0; m_prev = d; step = 1;
        end else begin
            m_run++;
            step = (m_run == D || (m_run > D && (m_run - D) % R == 0)) ? 1 : 0;
        end
        if (step != 0) m_angle = (m_angle + d + 16) % 16;
        m_upd = step;
        exp_vec(m_angle, m_dx, m_dy);
    endtask

    task automatic drive(input logic ft, input logic l, input logic r, input logic lk);
        @(negedge clk);
        frame_tick = ft; btn_left = l; btn_right = r; lock = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int ex, ey;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_angle", int'(angle), INIT);
        chk("reset_upd", int'(angle_upd), 0);
        chk("reset_dx", int'(dx), 0);
        chk("reset_dy", int'(dy), 0);
        repeat (2) @(negedge clk);
        frame_tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0; lock = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // one tick then one quiet cycle; checks pulse and angle on both
    task automatic tick_seq(input string nm, input logic l, input logic r, input logic lk,
                            input int e_upd, input int e_ang);
        drive(1'b1, l, r, lk);
        chk({nm, "_upd"}, int'(angle_upd), e_upd);
        chk({nm, "_ang"}, int'(angle), e_ang);
        drive(1'b0, l, r, lk);
        chk({nm, "_upd_gap"}, int'(angle_upd), 0);
    endtask

    initial begin
        int ex, ey, exp_ang;
        logic l, r, lk;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd4,  1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd4,  1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd4,  1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd4,  1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd2,  1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1,  1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd15, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  1'b1};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1,  1'b0};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1,  1'b0};

        model_reset();
        do_reset();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].ft, tbl[i].l, tbl[i].r, tbl[i].lk);
            chk($sformatf("tbl%0d_ang", i), int'(angle), int'(tbl[i].ang));
            chk($sformatf("tbl%0d_upd", i), int'(angle_upd), int'(tbl[i].upd));
            exp_vec(int'(tbl[i].ang), ex, ey);
            chk($sformatf("tbl%0d_dx", i), int'(dx), ex);
            chk($sformatf("tbl%0d_dy", i), int'(dy), ey);
        end

        // right held 30 ticks: steps at 0,12,16,20,24,28
        do_reset();
        exp_ang = INIT;
        for (int i = 0; i < 30; i++) begin
            int st;
            st = (i == 0 || i == 12 || i == 16 || i == 20 || i == 24 || i == 28) ? 1 : 0;
            exp_ang = exp_ang + st;
            tick_seq($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b0, st, exp_ang);
        end
        chk("hold_final", int'(angle), 10);

        // right 5 ticks, then left: immediate step, next 12 ticks later; then both held
        do_reset();
        for (int i = 0; i < 5; i++) tick_seq($sformatf("sw_r%0d", i), 1'b0, 1'b1, 1'b0, (i == 0) ? 1 : 0, 5);
        tick_seq("sw_left0", 1'b1, 1'b0, 1'b0, 1, 4);
        for (int i = 1; i < 12; i++) tick_seq($sformatf("sw_l%0d", i), 1'b1, 1'b0, 1'b0, 0, 4);
        tick_seq("sw_left12", 1'b1, 1'b0, 1'b0, 1, 3);
        for (int i = 0; i < 3; i++) tick_seq($sformatf("both%0d", i), 1'b1, 1'b1, 1'b0, 0, 3);
        tick_seq("after_both", 1'b0, 1'b1, 1'b0, 1, 4);

        // lock while holding right, then release with right still held
        do_reset();
        tick_seq("lk_press", 1'b0, 1'b1, 1'b0, 1, 5);
        for (int i = 0; i < 3; i++) tick_seq($sformatf("lk_on%0d", i), 1'b0, 1'b1, 1'b1, 0, 5);
        tick_seq("lk_release", 1'b0, 1'b1, 1'b0, 1, 6);
        for (int i = 1; i < 12; i++) tick_seq($sformatf("lk_wait%0d", i), 1'b0, 1'b1, 1'b0, 0, 6);
        tick_seq("lk_repeat", 1'b0, 1'b1, 1'b0, 1, 7);

        // randomized run against the model, with one mid-run reset
        do_reset();
        l = 1'b0; r = 1'b0; lk = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            logic ft;
            if (c == 2000) do_reset();
            if ($urandom_range(0, 59) == 0) l = ~l;
            if ($urandom_range(0, 59) == 0) r = ~r;
            if ($urandom_range(0, 149) == 0) lk = ~lk;
            ft = ($urandom_range(0, 2) == 0);
            drive(ft, l, r, lk);
            model_cycle(ft, l, r, lk);
            chk($sformatf("rnd%0d_ang", c), int'(angle), m_angle);
            chk($sformatf("rnd%0d_upd", c), int'(angle_upd), m_upd);
            chk($sformatf("rnd%0d_dx", c), int'(dx), m_dx);
            chk($sformatf("rnd%0d_dy", c), int'(dy), m_dy);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
